keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad, debounces it and emits one-cycle key events for password_fsm.

---
 rtl/keypad_pkg.sv | 60 ++++++
 rtl/keypad_debounce_fsm.sv | 116 +++++++++++
 rtl/keypad_scanner.sv | 121 ++++++++++++
 tb/tb_keypad_scanner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: key codes, FSM state
// encoding, frame result encoding and the (row,col) -> code map.
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEB,
        ST_ACCEPT,
        ST_HELD,
        ST_REL
    } state_e;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_ONE,
        FR_MULTI
    } frame_res_e;

    // Physical layout: r0: 1 2 3 A  r1: 4 5 6 B  r2: 7 8 9 C  r3: * 0 # D
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = KEY_1;
            4'h1:    code = KEY_2;
            4'h2:    code = KEY_3;
            4'h3:    code = KEY_A;
            4'h4:    code = KEY_4;
            4'h5:    code = KEY_5;
            4'h6:    code = KEY_6;
            4'h7:    code = KEY_B;
            4'h8:    code = KEY_7;
            4'h9:    code = KEY_8;
            4'hA:    code = KEY_9;
            4'hB:    code = KEY_C;
            4'hC:    code = KEY_STAR;
            4'hD:    code = KEY_0;
            4'hE:    code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Debounce / accept / release state machine. Consumes one frame result per
// frame_close strobe (frame_res and frame_code are only meaningful while
// frame_close is high) and produces the one-cycle key/lock strobes.
module keypad_debounce_fsm
    import keypad_pkg::*;
#(
    parameter int         DEBOUNCE_FRAMES = 20,
    parameter logic [3:0] LOCK_CODE       = KEY_STAR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_close,
    input  frame_res_e frame_res,
    input  logic [3:0] frame_code,
    output logic       key_pulse,
    output logic [3:0] key_value,
    output logic       lock_pulse,
    output logic       key_held,
    output state_e     state_dbg
);

    localparam int             CW       = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);
    localparam logic [CW-1:0]  CNT_MAX  = '1;
    // With a single-frame debounce the first matching frame already accepts.
    localparam bit             SINGLE   = (DEBOUNCE_FRAMES <= 1);

    state_e        state;
    state_e        next_state;
    logic [CW-1:0] cnt;
    logic [3:0]    cand;
    logic          is_none;
    logic          is_one;

    assign is_none = (frame_res == FR_NONE);
    assign is_one  = (frame_res == FR_ONE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state decision, taken only on frame close (ACCEPT always lasts one cycle).
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (frame_close && is_one) next_state = SINGLE ? ST_ACCEPT : ST_DEB;
            end
            ST_DEB: begin
                if (frame_close) begin
                    if (!is_one)                                     next_state = ST_IDLE;
                    else if (frame_code == cand && cnt >= CNT_LAST)  next_state = ST_ACCEPT;
                end
            end
            ST_ACCEPT: next_state = ST_HELD;
            ST_HELD: begin
                if (frame_close && is_none) next_state = SINGLE ? ST_IDLE : ST_REL;
            end
            ST_REL: begin
                if (frame_close) begin
                    if (!is_none)             next_state = ST_HELD;
                    else if (cnt >= CNT_LAST) next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Candidate code, saturating frame counter and the held key_value register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            cand      <= '0;
            key_value <= '0;
        end else if (frame_close) begin
            case (state)
                ST_IDLE: begin
                    if (is_one) begin
                        cand <= frame_code;
                        cnt  <= CW'(1);
                    end
                end
                ST_DEB: begin
                    if (is_one) begin
                        if (frame_code == cand) begin
                            cnt <= (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
                        end else begin
                            cand <= frame_code;
                            cnt  <= CW'(1);
                        end
                    end
                end
                ST_HELD: begin
                    if (is_none) cnt <= CW'(1);
                end
                ST_REL: begin
                    if (is_none) cnt <= (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
                end
                default: ;
            endcase
            // Load key_value on the edge into ACCEPT so it is already valid with key_pulse.
            if (next_state == ST_ACCEPT && frame_code != LOCK_CODE) key_value <= frame_code;
        end
    end

    // Outputs decoded from state; the strobes are high only during ACCEPT.
    always_comb begin
        key_pulse  = (state == ST_ACCEPT) && (cand != LOCK_CODE);
        lock_pulse = (state == ST_ACCEPT) && (cand == LOCK_CODE);
        key_held   = (state == ST_ACCEPT) || (state == ST_HELD) || (state == ST_REL);
        state_dbg  = state;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column synchronizer, row dwell/rotation counters and
// the per-frame decoder feeding the debounce FSM.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int         SCAN_DIV        = 24_000,
    parameter int         DEBOUNCE_FRAMES = 20,
    parameter logic [3:0] LOCK_CODE       = KEY_STAR
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       key_pulse,
    output logic [3:0] key_value,
    output logic       lock_pulse,
    output logic       key_held
);

    localparam int            DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    col_meta;
    logic [3:0]    col_sync;
    logic [DW-1:0] dwell;
    logic [1:0]    row_idx;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_code;
    logic          sample;
    logic          frame_close;
    logic [3:0]    row_press;
    logic [2:0]    row_hits;
    logic [1:0]    row_col;
    logic [2:0]    hits_total;
    logic [3:0]    frame_code;
    frame_res_e    frame_res;
    state_e        fsm_state;

    // Two-flop synchronizer; resets to the idle (all released) level.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
        end
    end

    // Dwell counter with exact SCAN_DIV period; row index advances on wrap.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dwell   <= '0;
            row_idx <= 2'd0;
        end else if (dwell == DWELL_LAST) begin
            dwell   <= '0;
            row_idx <= row_idx + 2'd1;
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    assign row_out     = ~(4'b0001 << row_idx);
    assign sample      = (dwell == DWELL_LAST);
    assign frame_close = sample && (row_idx == 2'd3);
    assign row_press   = ~col_sync;

    // Per-row hit count and lowest pressed column, folded into the frame tally.
    always_comb begin
        row_hits = 3'd0;
        row_col  = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (row_press[c]) begin
                row_hits = row_hits + 3'd1;
                row_col  = 2'(c);
            end
        end
        hits_total = {1'b0, acc_cnt} + row_hits;
        frame_code = (row_hits != 3'd0) ? key_code(row_idx, row_col) : acc_code;
        if (hits_total == 3'd0)      frame_res = FR_NONE;
        else if (hits_total == 3'd1) frame_res = FR_ONE;
        else                         frame_res = FR_MULTI;
    end

    // Frame accumulator: saturates at two hits, cleared when the frame closes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_cnt  <= 2'd0;
            acc_code <= 4'h0;
        end else if (sample) begin
            if (row_idx == 2'd3) begin
                acc_cnt  <= 2'd0;
                acc_code <= 4'h0;
            end else begin
                acc_cnt  <= (hits_total >= 3'd2) ? 2'd2 : hits_total[1:0];
                acc_code <= frame_code;
            end
        end
    end

    keypad_debounce_fsm #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .LOCK_CODE       (LOCK_CODE)
    ) u_fsm (
        .clk         (CLK),
        .reset       (RESET),
        .frame_close (frame_close),
        .frame_res   (frame_res),
        .frame_code  (frame_code),
        .key_pulse   (key_pulse),
        .key_value   (key_value),
        .lock_pulse  (lock_pulse),
        .key_held    (key_held),
        .state_dbg   (fsm_state)
    );

    // ACCEPT is a single-cycle state that always hands over to HELD.
    accept_one_cycle: assert property (@(posedge CLK) disable iff (RESET)
        (fsm_state == ST_ACCEPT) |=> (fsm_state == ST_HELD));

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3
// (16-cycle frames). A small keypad model drives col_in from row_out.
// Cycle n is the n-th cycle after reset release; frame f closes in cycle
// 16f+15 and an accepted key strobes in cycle 16f+16.
module tb_keypad_scanner;

    logic       CLK;
    logic       RESET;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic       key_pulse;
    logic [3:0] key_value;
    logic       lock_pulse;
    logic       key_held;

    logic [3:0][3:0] pressed;   // pressed[row][col]
    int cyc;
    int n_checks;
    int n_fail;
    int kp_count;
    int lp_count;
    int kp_base;
    int lp_base;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3),
        .LOCK_CODE       (4'hE)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .col_in     (col_in),
        .row_out    (row_out),
        .key_pulse  (key_pulse),
        .key_value  (key_value),
        .lock_pulse (lock_pulse),
        .key_held   (key_held)
    );

    // Clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Keypad model: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_out[r]) col_in = col_in & ~pressed[r];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Pulse monitor on the falling edge; the two strobes must never coincide.
    always @(negedge CLK) begin
        if (key_pulse === 1'b1)  kp_count++;
        if (lock_pulse === 1'b1) lp_count++;
        if (key_pulse === 1'b1 || lock_pulse === 1'b1)
            check_eq("pulse_excl", 32'(key_pulse & lock_pulse), 32'd0);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        kp_count = 0;
        lp_count = 0;
        cyc      = 0;
        pressed  = '0;
        RESET    = 1'b1;

        // 1. Reset values and row rotation.
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_row_out",  32'(row_out), 32'hE);
        check_eq("rst_kpulse",   32'(key_pulse), 32'd0);
        check_eq("rst_kvalue",   32'(key_value), 32'd0);
        check_eq("rst_lpulse",   32'(lock_pulse), 32'd0);
        check_eq("rst_held",     32'(key_held), 32'd0);
        RESET = 1'b0;
        cyc   = 0;
        check_eq("row_c0",  32'(row_out), 32'hE);
        run_to(3);  check_eq("row_c3",  32'(row_out), 32'hE);
        run_to(4);  check_eq("row_c4",  32'(row_out), 32'hD);
        run_to(8);  check_eq("row_c8",  32'(row_out), 32'hB);
        run_to(12); check_eq("row_c12", 32'(row_out), 32'h7);
        run_to(16); check_eq("row_c16", 32'(row_out), 32'hE);

        // 2. '5' held frames 1..5, accepted after frame 3 closes (cycle 63).
        kp_base = kp_count;
        pressed[1][1] = 1'b1;
        run_to(63); check_eq("t5_early",  32'(key_pulse), 32'd0);
        run_to(64);
        check_eq("t5_pulse", 32'(key_pulse), 32'd1);
        check_eq("t5_value", 32'(key_value), 32'd5);
        check_eq("t5_held",  32'(key_held), 32'd1);
        run_to(65); check_eq("t5_width", 32'(key_pulse), 32'd0);
        run_to(96); pressed[1][1] = 1'b0;
        run_to(143); check_eq("t5_held_late", 32'(key_held), 32'd1);
        run_to(144); check_eq("t5_released",  32'(key_held), 32'd0);
        check_eq("t5_count", 32'(kp_count - kp_base), 32'd1);

        // 4. '*' held frames 9..12: lock strobe after frame 11 (cycle 192).
        kp_base = kp_count;
        lp_base = lp_count;
        pressed[3][0] = 1'b1;
        run_to(191); check_eq("lock_early", 32'(lock_pulse), 32'd0);
        run_to(192);
        check_eq("lock_pulse", 32'(lock_pulse), 32'd1);
        check_eq("lock_kpulse", 32'(key_pulse), 32'd0);
        check_eq("lock_kvalue", 32'(key_value), 32'd5);
        check_eq("lock_held", 32'(key_held), 32'd1);
        run_to(193); check_eq("lock_width", 32'(lock_pulse), 32'd0);
        run_to(208); pressed[3][0] = 1'b0;
        run_to(255); check_eq("lock_held_late", 32'(key_held), 32'd1);
        run_to(256); check_eq("lock_released",  32'(key_held), 32'd0);
        check_eq("lock_lcount", 32'(lp_count - lp_base), 32'd1);
        check_eq("lock_kcount", 32'(kp_count - kp_base), 32'd0);

        // 3. Bounce on '3' (col2, row0) every 3 cycles for frames 16-17, then steady.
        //    Frame 16 sees it, frame 17 does not; clean frames 18..20 -> cycle 336.
        kp_base = kp_count;
        while (cyc < 288) begin
            pressed[0][2] = (((cyc - 256) / 3) % 2) == 0;
            tick();
        end
        pressed[0][2] = 1'b1;
        run_to(335);
        check_eq("bnc_early", 32'(key_pulse), 32'd0);
        check_eq("bnc_none",  32'(kp_count - kp_base), 32'd0);
        run_to(336);
        check_eq("bnc_pulse", 32'(key_pulse), 32'd1);
        check_eq("bnc_value", 32'(key_value), 32'd3);
        run_to(352); pressed[0][2] = 1'b0;
        run_to(400);
        check_eq("bnc_released", 32'(key_held), 32'd0);
        check_eq("bnc_count", 32'(kp_count - kp_base), 32'd1);

        // 5. '1'+'2' together frames 25..30 (MULTI), then '1' alone from frame 31.
        kp_base = kp_count;
        pressed[0][0] = 1'b1;
        pressed[0][1] = 1'b1;
        run_to(496);
        check_eq("multi_none", 32'(kp_count - kp_base), 32'd0);
        check_eq("multi_held", 32'(key_held), 32'd0);
        pressed[0][1] = 1'b0;
        run_to(543); check_eq("multi_early", 32'(key_pulse), 32'd0);
        run_to(544);
        check_eq("multi_pulse", 32'(key_pulse), 32'd1);
        check_eq("multi_value", 32'(key_value), 32'd1);
        run_to(560); pressed[0][0] = 1'b0;
        run_to(608); check_eq("multi_released", 32'(key_held), 32'd0);

        // 6. '9' pressed, reset for 2 cycles while in DEB, key kept down.
        pressed[2][2] = 1'b1;
        run_to(630);
        RESET = 1'b1;
        tick();
        tick();
        check_eq("mid_rst_row",   32'(row_out), 32'hE);
        check_eq("mid_rst_held",  32'(key_held), 32'd0);
        check_eq("mid_rst_value", 32'(key_value), 32'd0);
        check_eq("mid_rst_pulse", 32'(key_pulse), 32'd0);
        RESET = 1'b0;
        cyc = 0;
        kp_base = kp_count;
        run_to(47);
        check_eq("rst9_early", 32'(key_pulse), 32'd0);
        check_eq("rst9_none",  32'(kp_count - kp_base), 32'd0);
        run_to(48);
        check_eq("rst9_pulse", 32'(key_pulse), 32'd1);
        check_eq("rst9_value", 32'(key_value), 32'd9);
        run_to(49); check_eq("rst9_width", 32'(key_pulse), 32'd0);
        run_to(64); pressed[2][2] = 1'b0;
        run_to(111); check_eq("rst9_held_late", 32'(key_held), 32'd1);
        run_to(112); check_eq("rst9_released",  32'(key_held), 32'd0);
        check_eq("rst9_count", 32'(kp_count - kp_base), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
